// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  localparam int PC_W_DEF = 10;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Wide sign extension; callers truncate to their PC width.
  function automatic logic signed [31:0] sext8(input logic [7:0] off);
    return {{24{off[7]}}, off};
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack; pointer counts occupied entries (0..DEPTH).
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = AW'(sp - 1'b1);
  assign full   = (sp == (AW+1)'(DEPTH));
  assign empty  = (sp == '0);
  assign dout   = mem[rd_idx];

  // Overflowing pushes and underflowing pops are silently dropped here;
  // the sequencer records them in its sticky flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control, next-PC selection,
// return-address stack and sticky stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int START_PC = 0,
  parameter int RS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            BrAbs,
  input  logic            BrRel,
  input  logic            Taken,
  input  logic            Call,
  input  logic            Ret,
  input  logic [PC_W-1:0] Target,
  input  logic [7:0]      RelOff,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done,
  output logic            RsOvf,
  output logic            RsUnf
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] rs_dout;
  logic            rs_push;
  logic            rs_pop;
  logic            rs_clear;
  logic            rs_full;
  logic            rs_empty;
  logic            ovf_nxt;
  logic            unf_nxt;

  // Both adders wrap modulo 2^PC_W by construction.
  assign pc_inc = PC + 1'b1;
  assign pc_rel = PC + PC_W'(sext8(RelOff));

  ret_stack #(
    .DEPTH (RS_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (rs_clear),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pc_inc),
    .dout  (rs_dout),
    .full  (rs_full),
    .empty (rs_empty)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    rs_push   = 1'b0;
    rs_pop    = 1'b0;
    rs_clear  = 1'b0;
    ovf_nxt   = RsOvf;
    unf_nxt   = RsUnf;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = PC_W'(START_PC);
          rs_clear  = 1'b1;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (Halt) begin
          state_nxt = HALT;
        end else if (Ret) begin
          if (!rs_empty) begin
            pc_nxt = rs_dout;
            rs_pop = 1'b1;
          end else begin
            pc_nxt  = pc_inc;
            unf_nxt = 1'b1;
          end
        end else if (Call) begin
          // The jump is taken even when the return address cannot be saved.
          pc_nxt = Target;
          if (!rs_full) rs_push = 1'b1;
          else          ovf_nxt = 1'b1;
        end else if (BrAbs && Taken) begin
          pc_nxt = Target;
        end else if (BrRel && Taken) begin
          pc_nxt = pc_rel;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      PC    <= PC_W'(START_PC);
      RsOvf <= 1'b0;
      RsUnf <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      RsOvf <= ovf_nxt;
      RsUnf <= unf_nxt;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an abstract reference model checked every cycle.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Halt = 1'b0;
  logic       BrAbs = 1'b0;
  logic       BrRel = 1'b0;
  logic       Taken = 1'b0;
  logic       Call = 1'b0;
  logic       Ret = 1'b0;
  logic [9:0] Target = '0;
  logic [7:0] RelOff = '0;
  logic [9:0] PC;
  logic       Running;
  logic       Done;
  logic       RsOvf;
  logic       RsUnf;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int m_st = 0;
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  pc_sequencer dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Halt    (Halt),
    .BrAbs   (BrAbs),
    .BrRel   (BrRel),
    .Taken   (Taken),
    .Call    (Call),
    .Ret     (Ret),
    .Target  (Target),
    .RelOff  (RelOff),
    .PC      (PC),
    .Running (Running),
    .Done    (Done),
    .RsOvf   (RsOvf),
    .RsUnf   (RsUnf)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_st = 0; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_st != 1) begin
      if (Start) begin
        m_st = 1; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end
    end else if (Halt) begin
      m_st = 2;
    end else if (Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) & 1023; m_unf = 1; end
    end else if (Call) begin
      if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) & 1023);
      else m_ovf = 1;
      m_pc = int'(Target);
    end else if (BrAbs && Taken) begin
      m_pc = int'(Target);
    end else if (BrRel && Taken) begin
      m_pc = (m_pc + int'($signed(RelOff))) & 1023;
    end else begin
      m_pc = (m_pc + 1) & 1023;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_pc", 32'(PC), 32'(m_pc));
      chk("model_running", 32'(Running), 32'(m_st == 1));
      chk("model_done", 32'(Done), 32'(m_st == 2));
      chk("model_ovf", 32'(RsOvf), 32'(m_ovf));
      chk("model_unf", 32'(RsUnf), 32'(m_unf));
    end
  end

  task automatic idle_in();
    Start = 0; Halt = 0; BrAbs = 0; BrRel = 0; Taken = 0; Call = 0; Ret = 0;
    Target = '0; RelOff = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic br_abs(input logic [9:0] tgt, input logic tk);
    BrAbs = 1; Taken = tk; Target = tgt;
    tick();
    idle_in();
  endtask

  task automatic do_call(input logic [9:0] tgt);
    Call = 1; Target = tgt;
    tick();
    idle_in();
  endtask

  task automatic do_ret();
    Ret = 1;
    tick();
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] ret_exp [4];
    ret_exp[0] = 10'h104; ret_exp[1] = 10'h103; ret_exp[2] = 10'h102; ret_exp[3] = 10'h001;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_running", 32'(Running), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    cmp_en = 1;
    Reset = 1;
    tick();
    chk("idle_hold", 32'(Running), 32'd0);

    Start = 1;
    tick();
    Start = 0;
    chk("start_pc", 32'(PC), 32'd0);
    chk("start_running", 32'(Running), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(PC), 32'(i));
    end

    br_abs(10'd4, 1);
    chk("goto4", 32'(PC), 32'd4);
    br_abs(10'h1B7, 1);
    chk("abs_taken", 32'(PC), 32'h1B7);
    br_abs(10'd4, 1);
    br_abs(10'h1B7, 0);
    chk("abs_not_taken", 32'(PC), 32'd5);

    br_abs(10'd2, 1);
    BrRel = 1; Taken = 1; RelOff = 8'hFD;
    tick();
    idle_in();
    chk("rel_wrap_neg", 32'(PC), 32'h3FF);
    tick();
    chk("inc_wrap", 32'(PC), 32'd0);

    for (int k = 0; k < 4; k++) begin
      do_call(10'h100);
      chk("call_pc", 32'(PC), 32'h100);
      repeat (k + 1) tick();
    end
    chk("pre_ovf_pc", 32'(PC), 32'h104);
    chk("pre_ovf_flag", 32'(RsOvf), 32'd0);
    do_call(10'h100);
    chk("ovf_pc", 32'(PC), 32'h100);
    chk("ovf_flag", 32'(RsOvf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      do_ret();
      chk("ret_pc", 32'(PC), 32'(ret_exp[k]));
    end
    chk("pre_unf_flag", 32'(RsUnf), 32'd0);
    do_ret();
    chk("unf_pc", 32'(PC), 32'd2);
    chk("unf_flag", 32'(RsUnf), 32'd1);

    br_abs(10'h1D6, 1);
    Halt = 1; BrAbs = 1; Taken = 1; Target = 10'h055;
    tick();
    idle_in();
    chk("halt_pc", 32'(PC), 32'h1D6);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_running", 32'(Running), 32'd0);
    tick();
    chk("halt_frozen", 32'(PC), 32'h1D6);
    Start = 1;
    tick();
    Start = 0;
    chk("restart_pc", 32'(PC), 32'd0);
    chk("restart_done", 32'(Done), 32'd0);
    chk("restart_ovf", 32'(RsOvf), 32'd0);
    chk("restart_unf", 32'(RsUnf), 32'd0);

    br_abs(10'h1F8, 1);
    chk("pre_rst_pc", 32'(PC), 32'h1F8);
    Start = 1;
    tick();
    Start = 0;
    chk("start_ignored", 32'(PC), 32'h1F9);
    #3;
    Reset = 0;
    #1;
    chk("async_rst_pc", 32'(PC), 32'd0);
    chk("async_rst_running", 32'(Running), 32'd0);
    tick();
    Reset = 1;
    tick();
    chk("post_rst_idle", 32'(Running), 32'd0);
    Start = 1;
    tick();
    Start = 0;
    tick();
    chk("post_rst_run", 32'(PC), 32'd1);
    @(negedge Clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
